// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, load-use stall and memory freeze sequencing.
// Optional `HAZARD_STATS_EN adds saturating redirect/stall event counters.
module hazard_ctrl #(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       redirect,
    input  logic [1:0] PC_sel_in,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       mem_busy,
    output logic [1:0] PC_sel_out,
    output logic       PC_write,
    output logic       IFID_write,
    output logic       IFID_flush,
    output logic       IDEX_flush,
    output logic       is_flushed,
`ifdef HAZARD_STATS_EN
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic [1:0] state
);

    localparam logic [1:0] RUN       = 2'b00;
    localparam logic [1:0] STALL_LU  = 2'b01;
    localparam logic [1:0] STALL_MEM = 2'b10;
    localparam logic [1:0] REDIRECT  = 2'b11;
    localparam logic [1:0] CNT_INIT  = 2'(FLUSH_DEPTH - 1);

    logic [1:0] cnt, cnt_nxt;
    logic [1:0] state_nxt;
    logic       pend, pend_nxt;
    logic [1:0] pend_sel, pend_sel_nxt;
    logic       flush_once, flush_once_nxt;
    logic       apply;
    logic [1:0] apply_sel;
    logic       load_use;

    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        PC_sel_out     = 2'b00;
        PC_write       = 1'b1;
        IFID_write     = 1'b1;
        IFID_flush     = 1'b0;
        IDEX_flush     = 1'b0;
        is_flushed     = (state == REDIRECT) || flush_once;
        state_nxt      = state;
        cnt_nxt        = cnt;
        pend_nxt       = pend;
        pend_sel_nxt   = pend_sel;
        flush_once_nxt = 1'b0;
        apply          = 1'b0;
        apply_sel      = PC_sel_in;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    PC_write   = 1'b0;
                    IFID_write = 1'b0;
                    state_nxt  = STALL_MEM;
                    if (redirect) begin
                        pend_nxt     = 1'b1;
                        pend_sel_nxt = PC_sel_in;
                    end
                end else if (redirect) begin
                    apply = 1'b1;
                end else if (load_use) begin
                    PC_write   = 1'b0;
                    IFID_write = 1'b0;
                    IDEX_flush = 1'b1;
                    state_nxt  = STALL_LU;
                end
            end
            STALL_LU: state_nxt = RUN;
            STALL_MEM: begin
                if (mem_busy) begin
                    PC_write   = 1'b0;
                    IFID_write = 1'b0;
                    if (redirect) begin
                        pend_nxt     = 1'b1;
                        pend_sel_nxt = PC_sel_in;
                    end
                end else if (pend) begin
                    apply     = 1'b1;
                    apply_sel = pend_sel;
                    pend_nxt  = 1'b0;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                // Redirects arriving while the flush window is open are dropped.
                if (cnt == 2'd0) state_nxt = RUN;
                else             cnt_nxt   = cnt - 2'd1;
            end
        endcase
        if (apply) begin
            PC_sel_out = apply_sel;
            PC_write   = 1'b1;
            IFID_write = 1'b1;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            if (FLUSH_DEPTH == 1) begin
                state_nxt      = RUN;
                flush_once_nxt = 1'b1;
            end else begin
                state_nxt = REDIRECT;
                cnt_nxt   = CNT_INIT;
            end
        end
        if (!rst) begin
            PC_sel_out = 2'b00;
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            is_flushed = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            cnt        <= 2'd0;
            pend       <= 1'b0;
            pend_sel   <= 2'b00;
            flush_once <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pend       <= pend_nxt;
            pend_sel   <= pend_sel_nxt;
            flush_once <= flush_once_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            redirect_cnt <= 32'd0;
            stall_cnt    <= 32'd0;
        end else begin
            if (apply && (redirect_cnt != 32'hFFFF_FFFF)) redirect_cnt <= redirect_cnt + 32'd1;
            if (!PC_write && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl (FLUSH_DEPTH=2) against a behavioural pipeline model.
module tb_hazard_ctrl;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst, redirect, ex_is_load, id_use_rs1, id_use_rs2, mem_busy;
    logic [1:0] PC_sel_in, PC_sel_out, state;
    logic [4:0] ex_rd, id_rs1, id_rs2;
    logic       PC_write, IFID_write, IFID_flush, IDEX_flush, is_flushed;
`ifdef HAZARD_STATS_EN
    logic [31:0] redirect_cnt, stall_cnt;
`endif

    hazard_ctrl #(.FLUSH_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .PC_sel_in(PC_sel_in),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .mem_busy(mem_busy),
        .PC_sel_out(PC_sel_out), .PC_write(PC_write), .IFID_write(IFID_write),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .is_flushed(is_flushed),
`ifdef HAZARD_STATS_EN
        .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: pipeline frozen by memory, remaining flushed cycles, one-cycle load-use recovery, parked redirect.
    bit       m_frozen, m_lu, m_pv, n_frozen, n_lu, n_pv;
    int       m_fl, n_fl;
    bit [1:0] m_ps, n_ps;
    logic [8:0] exp_v;

    function automatic logic [8:0] obs();
        return {PC_sel_out, PC_write, IFID_write, IFID_flush, IDEX_flush, is_flushed, state};
    endfunction

    task automatic step(input logic r, input logic red, input logic [1:0] sel, input logic ld,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic mb);
        bit [1:0] e_sel, e_st;
        bit e_pw, e_iw, e_ff, e_df, e_isf, hz, ap;
        bit [1:0] ap_sel;
        @(negedge clk);
        m_frozen = n_frozen; m_lu = n_lu; m_pv = n_pv; m_fl = n_fl; m_ps = n_ps;
        rst = r; redirect = red; PC_sel_in = sel; ex_is_load = ld; ex_rd = rd;
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; mem_busy = mb;
        #1;
        hz = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e_st = m_frozen ? 2'd2 : (m_fl > 0) ? 2'd3 : m_lu ? 2'd1 : 2'd0;
        e_sel = 0; e_pw = 1; e_iw = 1; e_ff = 0; e_df = 0; e_isf = 0; ap = 0; ap_sel = sel;
        n_frozen = m_frozen; n_lu = m_lu; n_pv = m_pv; n_fl = m_fl; n_ps = m_ps;
        if (!r) begin
            e_pw = 0; e_iw = 0; e_ff = 1; e_df = 1; e_isf = 1;
            n_frozen = 0; n_lu = 0; n_pv = 0; n_fl = 0;
        end else if (m_frozen) begin
            if (mb) begin
                e_pw = 0; e_iw = 0;
                if (red) begin n_pv = 1; n_ps = sel; end
            end else if (m_pv) begin
                ap = 1; ap_sel = m_ps; n_pv = 0;
            end else n_frozen = 0;
        end else if (m_fl > 0) begin
            e_isf = 1; n_fl = m_fl - 1;
        end else if (m_lu) begin
            n_lu = 0;
        end else if (mb) begin
            e_pw = 0; e_iw = 0; n_frozen = 1;
            if (red) begin n_pv = 1; n_ps = sel; end
        end else if (red) begin
            ap = 1;
        end else if (hz) begin
            e_pw = 0; e_iw = 0; e_df = 1; n_lu = 1;
        end
        if (ap) begin
            e_sel = ap_sel; e_ff = 1; e_df = 1; n_frozen = 0; n_fl = DEPTH;
        end
        exp_v = {e_sel, e_pw, e_iw, e_ff, e_df, e_isf, e_st};
    endtask

    task automatic idle();
        step(1, 0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 2'b11, 1, 5'd3, 5'd3, 5'd3, 1, 1, 0);
            n_cmp++;
            if ({PC_sel_out, PC_write, IFID_write, IFID_flush, IDEX_flush, is_flushed} !== 7'b00_00111) begin
                n_fail++; $display("FAIL reset_outputs: got %b want 0000111",
                    {PC_sel_out, PC_write, IFID_write, IFID_flush, IDEX_flush, is_flushed});
            end
        end
        idle();
        n_cmp++;
        if (state !== 2'b00 || PC_write !== 1'b1 || is_flushed !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got state=%b pcw=%b isf=%b want 00 1 0", state, PC_write, is_flushed);
        end
    endtask

    task automatic test_redirect();
        step(1, 1, 2'b10, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        n_cmp++;
        if ({PC_sel_out, IFID_flush, IDEX_flush, PC_write} !== 5'b10_111) begin
            n_fail++; $display("FAIL redirect_same_cycle: got %b want 10111", {PC_sel_out, IFID_flush, IDEX_flush, PC_write});
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            n_cmp++;
            if (is_flushed !== 1'b1 || state !== 2'b11 || PC_sel_out !== 2'b00) begin
                n_fail++; $display("FAIL redirect_window%0d: got isf=%b state=%b sel=%b want 1 11 00", i, is_flushed, state, PC_sel_out);
            end
        end
        idle();
        n_cmp++;
        if (state !== 2'b00 || is_flushed !== 1'b0) begin
            n_fail++; $display("FAIL redirect_exit: got state=%b isf=%b want 00 0", state, is_flushed);
        end
    endtask

    task automatic test_load_use();
        step(1, 0, 2'b00, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0);
        n_cmp++;
        if ({PC_write, IFID_write, IDEX_flush, IFID_flush} !== 4'b0010) begin
            n_fail++; $display("FAIL load_use_stall: got %b want 0010", {PC_write, IFID_write, IDEX_flush, IFID_flush});
        end
        idle();
        n_cmp++;
        if (state !== 2'b01 || PC_write !== 1'b1 || IFID_write !== 1'b1) begin
            n_fail++; $display("FAIL load_use_recover: got state=%b pcw=%b ifw=%b want 01 1 1", state, PC_write, IFID_write);
        end
        idle();
        n_cmp++;
        if (state !== 2'b00) begin
            n_fail++; $display("FAIL load_use_return: got state=%b want 00", state);
        end
    endtask

    task automatic test_x0();
        step(1, 0, 2'b00, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0);
        n_cmp++;
        if (PC_write !== 1'b1 || IDEX_flush !== 1'b0) begin
            n_fail++; $display("FAIL x0_no_stall: got pcw=%b idex=%b want 1 0", PC_write, IDEX_flush);
        end
        idle();
        n_cmp++;
        if (state !== 2'b00) begin
            n_fail++; $display("FAIL x0_state: got state=%b want 00", state);
        end
    endtask

    task automatic test_mem_redirect();
        for (int i = 0; i < 3; i++) begin
            step(1, (i == 0), 2'b11, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
            n_cmp++;
            if ({PC_write, IFID_write, IFID_flush, IDEX_flush} !== 4'b0000) begin
                n_fail++; $display("FAIL mem_freeze%0d: got %b want 0000", i, {PC_write, IFID_write, IFID_flush, IDEX_flush});
            end
        end
        idle();
        n_cmp++;
        if ({PC_sel_out, IFID_flush, IDEX_flush, state} !== 6'b11_11_10) begin
            n_fail++; $display("FAIL mem_release_redirect: got %b want 111110", {PC_sel_out, IFID_flush, IDEX_flush, state});
        end
        repeat (DEPTH + 1) idle();
    endtask

    task automatic test_redirect_ignored();
        step(1, 1, 2'b01, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 1, 2'b11, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
            n_cmp++;
            if (PC_sel_out !== 2'b00 || IFID_flush !== 1'b0 || is_flushed !== 1'b1) begin
                n_fail++; $display("FAIL redirect_ignored%0d: got sel=%b iff=%b isf=%b want 00 0 1", i, PC_sel_out, IFID_flush, is_flushed);
            end
        end
        idle();
        n_cmp++;
        if (state !== 2'b00) begin
            n_fail++; $display("FAIL redirect_ignored_exit: got state=%b want 00", state);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 2'b10, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        idle();
        n_cmp++;
        if (state !== 2'b00 || is_flushed !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_redirect: got state=%b isf=%b want 00 0", state, is_flushed);
        end
        step(1, 1, 2'b01, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        step(0, 0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        idle();
        n_cmp++;
        if ({PC_sel_out, IFID_flush, state} !== 5'b00_0_00) begin
            n_fail++; $display("FAIL reset_mid_mem_pending: got %b want 00000", {PC_sel_out, IFID_flush, state});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 5) == 0), 2'($urandom_range(1, 3)),
                 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
            n_cmp++;
            if (obs() !== exp_v) begin
                n_fail++; $display("FAIL random_step%0d: got %b want %b (sel,pcw,ifw,iff,idf,isf,state)", i, obs(), exp_v);
            end
        end
    endtask

    initial begin
        rst = 0; redirect = 0; PC_sel_in = 0; ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; mem_busy = 0;
        n_frozen = 0; n_lu = 0; n_pv = 0; n_fl = 0; n_ps = 0;
        test_reset();
        test_redirect();
        test_load_use();
        test_x0();
        test_mem_redirect();
        test_redirect_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2, range 1-3: the number of cycles after a redirect during which the EX-stage instruction is marked as flushed.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, which is synchronous and active-low.
REQ-004 SHALL have port redirect, input, 1 bit: flush request from the EX-stage PC select logic.
REQ-005 SHALL have port PC_sel_in, input, 2 bits: PC source requested with redirect (01 branch, 10 JAL, 11 JALR).
REQ-006 SHALL have port ex_is_load, input, 1 bit: the EX-stage instruction is a load.
REQ-007 SHALL have ports ex_rd, id_rs1 and id_rs2, each input, 5 bits: the EX destination register and the ID source registers.
REQ-008 SHALL have ports id_use_rs1 and id_use_rs2, each input, 1 bit: the ID instruction reads rs1 / rs2.
REQ-009 SHALL have port mem_busy, input, 1 bit: data memory is not ready, so the whole pipeline freezes.
REQ-010 SHALL have port PC_sel_out, output, 2 bits: PC mux select (00 = PC+4).
REQ-011 SHALL have ports PC_write and IFID_write, each output, 1 bit: PC and IF/ID register enables.
REQ-012 SHALL have ports IFID_flush and IDEX_flush, each output, 1 bit: insert a bubble into that register.
REQ-013 SHALL have port is_flushed, output, 1 bit: the EX instruction is a killed bubble; it drives the PC select unit's is_flushed input.
REQ-014 SHALL have port state, output, 2 bits: current FSM state, for debug.

Function
REQ-015 SHALL implement FSM states RUN=00, STALL_LU=01, STALL_MEM=10 and REDIRECT=11.
REQ-016 SHALL evaluate conditions in RUN with priority mem_busy > redirect > load-use.
REQ-017 SHALL, in RUN with mem_busy=1, drive all of PC_write, IFID_write, IFID_flush and IDEX_flush to 0 and go to STALL_MEM.
REQ-018 SHALL, on a redirect during mem_busy, latch PC_sel_in into a pending register and set a pending flag.
REQ-019 SHALL, in STALL_MEM, hold all enables at 0 while mem_busy=1; on the first cycle with mem_busy=0, apply the pending redirect if set (as in REQ-020, clearing the flag), else return to RUN with normal enables.
REQ-020 SHALL, in RUN on redirect with no mem_busy, do all of the following in the same cycle (zero latency): PC_sel_out=PC_sel_in, PC_write=1, IFID_write=1, IFID_flush=1, IDEX_flush=1. Next state is REDIRECT with the counter loaded to FLUSH_DEPTH-1.
REQ-021 SHALL, if FLUSH_DEPTH=1, go directly to RUN instead of REDIRECT, with is_flushed asserted for exactly the next cycle.
REQ-022 SHALL, in REDIRECT, assert is_flushed=1 and PC_sel_out=00, ignore redirect, and decrement the counter each cycle; it exits to RUN when the counter is 0. is_flushed SHALL be high for exactly FLUSH_DEPTH cycles after the redirect cycle.
REQ-023 SHALL detect a load-use hazard when ex_is_load=1, ex_rd≠0, and ex_rd matches id_rs1 with id_use_rs1=1, or matches id_rs2 with id_use_rs2=1.
REQ-024 SHALL, in RUN on a load-use hazard, drive PC_write=0, IFID_write=0 and IDEX_flush=1 for one cycle, then go to STALL_LU.
REQ-025 SHALL, in STALL_LU, assert normal enables and return to RUN; a second hazard re-enters STALL_LU.
REQ-026 SHALL, in RUN with no event, drive PC_write=1, IFID_write=1, both flushes 0 and PC_sel_out=00.
REQ-027 SHALL have every output except state be a combinational function of state and inputs; state, the counter and the pending register are registered.
REQ-028 SHALL not overflow or wrap the counter: its width is 2 bits and it saturates at 0.

Reset
REQ-029 SHALL, when rst=0 at a clock edge, set state=RUN, counter=0 and pending flag=0.
REQ-030 SHALL force, while rst=0: PC_write=0, IFID_write=0, IFID_flush=1, IDEX_flush=1, is_flushed=1 and PC_sel_out=00.
REQ-031 SHALL let a reset asserted mid-REDIRECT or mid-STALL_MEM discard all pending redirects.

Configuration
REQ-032 SHALL, with HAZARD_STATS_EN defined, add 32-bit outputs redirect_cnt and stall_cnt. redirect_cnt increments on each applied redirect; stall_cnt increments on each cycle with PC_write=0 and rst=1. Both saturate at 0xFFFFFFFF and clear on reset.
REQ-033 SHALL, without HAZARD_STATS_EN, omit those ports and the counter logic entirely.

Verification
REQ-034 SHALL cover: redirect=1, PC_sel_in=10 in RUN -> same cycle PC_sel_out=10 and both flushes=1; is_flushed=1 for the next 2 cycles (FLUSH_DEPTH=2); then state=00.
REQ-035 SHALL cover: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle PC_write=0, IFID_write=0, IDEX_flush=1; next cycle state=01 with enables 1.
REQ-036 SHALL cover: ex_rd=0 with a matching load -> no stall.
REQ-037 SHALL cover: mem_busy=1 for 3 cycles with redirect, PC_sel_in=11 on the first -> enables 0 for 3 cycles; on the cycle mem_busy drops, PC_sel_out=11 and the flushes fire.
REQ-038 SHALL cover: redirect asserted during REDIRECT -> ignored; PC_sel_out stays 00.
REQ-039 SHALL cover: rst=0 in REDIRECT -> next cycle state=00, pending flag=0, and with HAZARD_STATS_EN both counters=0.
